// File: rtl/alarm_beeper_pkg.sv
// +-----------------------------------------------------------------------+
// | alarm_beeper_pkg : state encodings shared by the beeper and its users |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package alarm_beeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } beeper_state_t;

  localparam int unsigned c_STATE_WIDTH = 2;

  // True when a counter of the given width sits on its final value for a phase.
  function automatic logic at_last(input logic [31:0] ctr, input int unsigned len);
    return ctr == 32'(len - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_beeper.sv
// +-----------------------------------------------------------------------+
// | alarm_beeper : bounded piezo burst pattern driven by a 10 ms tick     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module alarm_beeper
  import alarm_beeper_pkg::*;
#(
  parameter int unsigned ON_TICKS   = 25,
  parameter int unsigned OFF_TICKS  = 25,
  parameter int unsigned BEEPS      = 4,
  parameter int unsigned TONE_HALF  = 1,
  parameter int unsigned CTR_WIDTH  = 8,
  parameter int unsigned BEEP_WIDTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic start,
  input  logic stop,
  output logic tone,
  output logic busy,
  output logic done
);

  beeper_state_t         r_state;
  beeper_state_t         w_state_nxt;
  logic [CTR_WIDTH-1:0]  r_tick_ctr;
  logic [CTR_WIDTH-1:0]  w_tick_nxt;
  logic [BEEP_WIDTH-1:0] r_beep_ctr;
  logic [BEEP_WIDTH-1:0] w_beep_nxt;
  logic [CTR_WIDTH-1:0]  r_tone_ctr;
  logic [CTR_WIDTH-1:0]  w_tone_ctr_nxt;
  logic                  r_tone;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_tone_nxt;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;

  logic w_tone_wrap;
  logic w_on_end;
  logic w_off_end;
  logic w_last_beep;

  assign w_tone_wrap = at_last(32'(r_tone_ctr), TONE_HALF);
  assign w_on_end    = enable && at_last(32'(r_tick_ctr), ON_TICKS);
  assign w_off_end   = enable && at_last(32'(r_tick_ctr), OFF_TICKS);
  assign w_last_beep = at_last(32'(r_beep_ctr), BEEPS);

  // State register and counters; outputs are registered here as well.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_tick_ctr <= '0;
      r_beep_ctr <= '0;
      r_tone_ctr <= '0;
      r_tone     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_ctr <= w_tick_nxt;
      r_beep_ctr <= w_beep_nxt;
      r_tone_ctr <= w_tone_ctr_nxt;
      r_tone     <= w_tone_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_tick_nxt     = r_tick_ctr;
    w_beep_nxt     = r_beep_ctr;
    w_tone_ctr_nxt = r_tone_ctr;
    if (stop) begin
      w_state_nxt    = ST_IDLE;
      w_tick_nxt     = '0;
      w_beep_nxt     = '0;
      w_tone_ctr_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_nxt    = ST_ON;
            w_tick_nxt     = '0;
            w_beep_nxt     = '0;
            w_tone_ctr_nxt = '0;
          end
        end
        ST_ON: begin
          w_tone_ctr_nxt = w_tone_wrap ? '0 : r_tone_ctr + 1'b1;
          if (w_on_end) begin
            w_state_nxt    = ST_OFF;
            w_tick_nxt     = '0;
            w_tone_ctr_nxt = '0;
          end else if (enable) begin
            w_tick_nxt = r_tick_ctr + 1'b1;
          end
        end
        ST_OFF: begin
          if (w_off_end) begin
            w_tick_nxt = '0;
            if (w_last_beep) begin
              w_state_nxt = ST_IDLE;
              w_beep_nxt  = '0;
            end else begin
              w_state_nxt    = ST_ON;
              w_beep_nxt     = r_beep_ctr + 1'b1;
              w_tone_ctr_nxt = '0;
            end
          end else if (enable) begin
            w_tick_nxt = r_tick_ctr + 1'b1;
          end
        end
        default: begin
          w_state_nxt    = ST_IDLE;
          w_tick_nxt     = '0;
          w_beep_nxt     = '0;
          w_tone_ctr_nxt = '0;
        end
      endcase
    end
  end

  // Next values of the registered outputs; stop forces all of them low.
  always_comb begin
    w_tone_nxt = 1'b0;
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    if (!stop) begin
      case (r_state)
        ST_IDLE: begin
          w_busy_nxt = start;
        end
        ST_ON: begin
          w_busy_nxt = 1'b1;
          if (!w_on_end) begin
            w_tone_nxt = w_tone_wrap ? ~r_tone : r_tone;
          end
        end
        ST_OFF: begin
          w_busy_nxt = !(w_off_end && w_last_beep);
          w_done_nxt = w_off_end && w_last_beep;
        end
        default: begin
          w_busy_nxt = 1'b0;
        end
      endcase
    end
  end

  assign tone = r_tone;
  assign busy = r_busy;
  assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_alarm_beeper.sv
// +-----------------------------------------------------------------------+
// | tb_alarm_beeper : directed and random checks against a phase model    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_alarm_beeper;

  localparam int ON_T  = 2;
  localparam int OFF_T = 3;
  localparam int NB    = 2;
  localparam int TH    = 1;

  logic clk = 1'b0;
  logic reset, enable, start, stop;
  logic tone, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  alarm_beeper #(
    .ON_TICKS  (ON_T),
    .OFF_TICKS (OFF_T),
    .BEEPS     (NB),
    .TONE_HALF (TH),
    .CTR_WIDTH (8),
    .BEEP_WIDTH(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .start (start),
    .stop  (stop),
    .tone  (tone),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Phase model: an alarm is a list of bursts, each measured in enable pulses
  // seen after entry; tone in a burst is floor(cycles/TH) mod 2.
  bit m_active, m_in_burst;
  int m_burst_no, m_en, m_cyc;
  logic m_tone, m_busy, m_done;

  int div = 0;
  int edge_no = 0;
  int last_one = -1;
  int zero_run = 100;
  int done_cnt = 0;
  int burst_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic rs, input logic sp, input logic st, input logic en);
    m_done = 1'b0;
    if (rs || sp) begin
      m_active = 0; m_in_burst = 0; m_tone = 0; m_busy = 0;
    end else if (!m_active) begin
      if (st) begin
        m_active = 1; m_in_burst = 1; m_burst_no = 0; m_en = 0; m_cyc = 0;
        m_tone = 0; m_busy = 1;
      end
    end else if (m_in_burst) begin
      m_cyc++;
      if (en) m_en++;
      if (m_en == ON_T) begin
        m_in_burst = 0; m_en = 0; m_tone = 0;
      end else begin
        m_tone = ((m_cyc / TH) % 2) == 1;
      end
    end else begin
      m_tone = 0;
      if (en) m_en++;
      if (m_en == OFF_T) begin
        m_en = 0;
        if (m_burst_no == NB - 1) begin
          m_active = 0; m_busy = 0; m_done = 1;
        end else begin
          m_burst_no++; m_in_burst = 1; m_cyc = 0;
        end
      end
    end
  endtask

  task automatic cyc(input logic st, input logic sp, input logic rs);
    start = st; stop = sp; reset = rs; enable = (div == 9);
    @(posedge clk);
    model_step(rs, sp, st, enable);
    div = (div == 9) ? 0 : div + 1;
    edge_no++;
    #1;
    chk("tone", tone, m_tone);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    if (done === 1'b1) done_cnt++;
    if (tone === 1'b1) begin
      if (zero_run >= 2) burst_cnt++;
      zero_run = 0;
      last_one = edge_no;
    end else begin
      zero_run++;
    end
  endtask

  task automatic run_to_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 400) begin
      cyc(0, 0, 0);
      n++;
    end
    chk(tag, busy, 1'b0);
  endtask

  task automatic clear_counts();
    done_cnt = 0; burst_cnt = 0; zero_run = 100;
  endtask

  initial begin
    int n;
    m_active = 0; m_in_burst = 0; m_burst_no = 0; m_en = 0; m_cyc = 0;
    m_tone = 0; m_busy = 0; m_done = 0;
    start = 0; stop = 0; reset = 1; enable = 0;

    // Reset state, then a long quiet idle
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk("rst_busy", busy, 1'b0);
    for (int i = 0; i < 100; i++) cyc(0, 0, 0);
    chk("idle_tone", tone, 1'b0);

    // Full alarm
    clear_counts();
    cyc(1, 0, 0);
    chk("start_busy", busy, 1'b1);
    run_to_idle("full_timeout");
    chk("full_done", done_cnt, 1);
    chk("full_bursts", burst_cnt, 2);

    // Abort during the second burst
    clear_counts();
    cyc(1, 0, 0);
    n = 0;
    while (!(m_in_burst && m_burst_no == 1) && n < 300) begin cyc(0, 0, 0); n++; end
    chk("abort_reach", n < 300, 1'b1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("abort_tone", tone, 1'b0);
    chk("abort_busy", busy, 1'b0);
    for (int i = 0; i < 40; i++) cyc(0, 0, 0);
    chk("abort_nodone", done_cnt, 0);

    // Start pulsed mid-gap of the first beep is ignored
    clear_counts();
    cyc(1, 0, 0);
    n = 0;
    while (!(m_active && !m_in_burst) && n < 300) begin cyc(0, 0, 0); n++; end
    for (int i = 0; i < 10; i++) cyc(0, 0, 0);
    cyc(1, 0, 0);
    run_to_idle("ign_timeout");
    chk("ign_done", done_cnt, 1);
    chk("ign_bursts", burst_cnt, 2);

    // Start with stop in idle
    cyc(1, 1, 0);
    chk("ss_busy", busy, 1'b0);
    cyc(0, 0, 0);
    chk("ss_busy2", busy, 1'b0);

    // Start coincident with enable: burst spans 2 further ticks (20 clk)
    while (div != 9) cyc(0, 0, 0);
    edge_no = -1; last_one = -1;
    cyc(1, 0, 0);
    for (int i = 0; i < 25; i++) cyc(0, 0, 0);
    chk("coinc_last_tone", last_one, 19);
    run_to_idle("coinc_timeout");

    // Reset mid-burst, then a fresh full alarm
    cyc(1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0);
    cyc(0, 0, 1);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_tone", tone, 1'b0);
    clear_counts();
    cyc(1, 0, 0);
    run_to_idle("rstmid_timeout");
    chk("rstmid_done", done_cnt, 1);
    chk("rstmid_bursts", burst_cnt, 2);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 29) == 0, $urandom_range(0, 149) == 0,
          $urandom_range(0, 399) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
